// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_pkg
// Description : Shared UART definitions: baud reference, parity modes,
//               transmitter state encodings and parity helper.
// Revision    : 1.0 - initial buffered-transmitter release
// ============================================================================
package uart_tx_fifo_pkg;

    // Baud reference: clock cycles per full elementary time unit.
    localparam int UART_FULL_ETU = 10416;

    // Parity modes.
    localparam int UART_PAR_NONE = 0;
    localparam int UART_PAR_ODD  = 1;
    localparam int UART_PAR_EVEN = 2;

    // Transmitter state encodings.
    localparam int         c_STATE_W    = 3;
    localparam logic [2:0] UART_TX_IDLE  = 3'd0;
    localparam logic [2:0] UART_TX_START = 3'd1;
    localparam logic [2:0] UART_TX_DATA  = 3'd2;
    localparam logic [2:0] UART_TX_PAR   = 3'd3;
    localparam logic [2:0] UART_TX_STOP  = 3'd4;

    // Parity bit over up to nine data bits; unused upper bits must be zero.
    function automatic logic uart_parity(input logic [8:0] data, input int mode);
        uart_parity = (mode == UART_PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with wrapping pointers and an occupancy
//               count. The caller qualifies push/pop against full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    // Storage array: write the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks net push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter. Queues words in a FIFO and sends
//               them LSB first with configurable data width, parity and stop
//               bits; frames run back-to-back while data is queued.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_FULL_ETU,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = UART_PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          rdy,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = 4;
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_dout;
    logic                 r_busy;
    logic                 r_ovf;

    logic [c_LVL_W-1:0]   w_level;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_done;
    logic                 w_idx_last;
    logic                 w_line;

    assign w_full     = (w_level == c_LVL_W'(FIFO_DEPTH));
    assign w_empty    = (w_level == '0);
    assign w_push     = en & ~w_full;
    assign w_bit_done = (r_bit_cnt == c_BIT_LAST);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (w_level)
    );

    // Next-state, pop request and line level for the current bit.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_line       = 1'b1;
        w_idx_last   = (r_state == UART_TX_DATA) ? (r_idx == c_DATA_LAST)
                                                 : (r_idx == c_STOP_LAST);
        case (r_state)
            UART_TX_IDLE: begin
                if (!w_empty) begin
                    w_next_state = UART_TX_START;
                    w_pop        = 1'b1;
                end
            end
            UART_TX_START: begin
                w_line = 1'b0;
                if (w_bit_done) begin
                    w_next_state = UART_TX_DATA;
                end
            end
            UART_TX_DATA: begin
                w_line = r_shift[0];
                if (w_bit_done && w_idx_last) begin
                    w_next_state = (PARITY != UART_PAR_NONE) ? UART_TX_PAR : UART_TX_STOP;
                end
            end
            UART_TX_PAR: begin
                w_line = r_parity;
                if (w_bit_done) begin
                    w_next_state = UART_TX_STOP;
                end
            end
            UART_TX_STOP: begin
                if (w_bit_done && w_idx_last) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!w_empty) begin
                        w_next_state = UART_TX_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_next_state = UART_TX_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = UART_TX_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= UART_TX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bit-time counter and data/stop index counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
        end else begin
            if (r_state == UART_TX_IDLE || w_bit_done) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
            if (w_bit_done && (r_state == UART_TX_DATA || r_state == UART_TX_STOP)) begin
                r_idx <= w_idx_last ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

    // Load the head word and its parity on pop; shift after each data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_shift  <= w_head;
            r_parity <= uart_parity(9'(w_head), PARITY);
        end else if (r_state == UART_TX_DATA && w_bit_done) begin
            r_shift  <= r_shift >> 1;
        end
    end

    // Registered outputs; the line lags the state by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= 1'b1;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_dout <= w_line;
            r_busy <= (w_next_state != UART_TX_IDLE);
            r_ovf  <= en & w_full;
        end
    end

    assign rdy   = ~w_full;
    assign dout  = r_dout;
    assign busy  = r_busy;
    assign level = w_level;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire
